rng_lfsr_gen: RTL and testbench

- Parametrised Fibonacci LFSR noise source for the wave generator datapath.
- Width, tap polynomial, seed and bits-per-word are configurable.
- Supports runtime seed reload with zero-seed lock-up protection, and enable gating.
- Delivers words over a valid/ready handshake and flags each full period.

---
 rtl/rng_lfsr_gen.sv | 118 +++++++++++
 tb/tb_rng_lfsr_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_lfsr_gen.sv
// rng_lfsr_gen: Fibonacci LFSR noise source for the wave generator datapath.
// The LFSR advances STEPS times per output word. Each finished word is held on
// o_data/o_valid until the consumer takes it, and the LFSR is frozen while a
// word is waiting. o_wrap marks every return of the LFSR to its last
// effective seed.
module rng_lfsr_gen #(
   parameter int unsigned      WIDTH = 12,
   parameter logic [WIDTH-1:0] TAPS  = 12'hE08,
   parameter logic [WIDTH-1:0] SEED  = 12'hACE,
   parameter int unsigned      STEPS = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_seed,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_wrap
);

   // The step counter needs at least one bit, even when STEPS is 1.
   localparam int unsigned    CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

   // Catch illegal parameter choices at elaboration time.
   if (WIDTH < 3 || WIDTH > 32) begin : g_badWidth
      $error("rng_lfsr_gen: WIDTH must be in 3..32");
   end
   if (STEPS < 1 || STEPS > WIDTH) begin : g_badSteps
      $error("rng_lfsr_gen: STEPS must be in 1..WIDTH");
   end
   if (SEED == '0) begin : g_badSeed
      $error("rng_lfsr_gen: SEED must be nonzero");
   end
   if (TAPS[WIDTH-1] != 1'b1) begin : g_badTaps
      $error("rng_lfsr_gen: TAPS must include bit WIDTH-1");
   end

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_lfsr;
   logic [WIDTH-1:0] r_start;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_wrap;

   logic             w_fb;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_seedEff;

   // Feedback is the parity of the tapped state bits, shifted into bit 0.
   assign w_fb   = ^(r_lfsr & TAPS);
   assign w_next = {r_lfsr[WIDTH-2:0], w_fb};

   // A zero seed would lock the LFSR at zero, so it is replaced by SEED.
   assign w_seedEff = (i_seed == '0) ? SEED : i_seed;

   // Single state machine: seed load overrides everything, FILL shifts and
   // assembles a word, HOLD parks the word until the consumer accepts it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= FILL;
         r_lfsr  <= SEED;
         r_start <= SEED;
         r_cnt   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (i_load) begin
            r_lfsr  <= w_seedEff;
            r_start <= w_seedEff;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_state <= FILL;
         end else begin
            case (r_state)
               FILL: begin
                  if (i_en) begin
                     r_lfsr <= w_next;
                     r_wrap <= (w_next == r_start);
                     if (r_cnt == CNT_LAST) begin
                        r_data  <= w_next;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= HOLD;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               HOLD: begin
                  if (r_valid && i_ready) begin
                     r_valid <= 1'b0;
                     r_state <= FILL;
                  end
               end
               default: begin
                  r_state <= FILL;
               end
            endcase
         end
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_rng_lfsr_gen.sv
// tb_rng_lfsr_gen: scoreboard bench for rng_lfsr_gen. Three instances
// (STEPS = 1, 2, 4) are driven by directed sequences; expected words are
// queued per instance and a monitor pops them on each accepted transfer.
module tb_rng_lfsr_gen;

   typedef struct packed {
      logic [11:0] data;
      logic        wrap;
   } expWord_t;

   logic clk;

   logic        rst1, en1, ld1, rdy1;
   logic [11:0] seed1, data1;
   logic        valid1, wrap1;

   logic        rst2, en2, ld2, rdy2;
   logic [11:0] seed2, data2;
   logic        valid2, wrap2;

   logic        rst4, en4, ld4, rdy4;
   logic [11:0] seed4, data4;
   logic        valid4, wrap4;

   expWord_t sbQueue[3][$];
   logic     prevValid[3];
   logic     riseWrap[3];

   int checks;
   int errors;

   rng_lfsr_gen #(.STEPS(1)) dut1 (
      .i_clk(clk), .i_rst(rst1), .i_en(en1), .i_load(ld1), .i_seed(seed1),
      .o_data(data1), .o_valid(valid1), .i_ready(rdy1), .o_wrap(wrap1)
   );

   rng_lfsr_gen #(.STEPS(2)) dut2 (
      .i_clk(clk), .i_rst(rst2), .i_en(en2), .i_load(ld2), .i_seed(seed2),
      .o_data(data2), .o_valid(valid2), .i_ready(rdy2), .o_wrap(wrap2)
   );

   rng_lfsr_gen #(.STEPS(4)) dut4 (
      .i_clk(clk), .i_rst(rst4), .i_en(en4), .i_load(ld4), .i_seed(seed4),
      .o_data(data4), .o_valid(valid4), .i_ready(rdy4), .o_wrap(wrap4)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference shift for the default 12-bit polynomial x^12+x^11+x^10+x^4+1.
   function automatic logic [11:0] lfsrStep(input logic [11:0] s);
      return {s[10:0], ^(s & 12'hE08)};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pushExp(input int idx, input logic [11:0] d, input logic w);
      expWord_t e;
      e.data = d;
      e.wrap = w;
      sbQueue[idx].push_back(e);
   endtask

   task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   task automatic applyStimulus1(input logic en, input logic rdy, input logic ld, input logic [11:0] sd);
      en1   = en;
      rdy1  = rdy;
      ld1   = ld;
      seed1 = sd;
   endtask

   // Monitor step for one instance: latch o_wrap when a word first appears,
   // then compare against the scoreboard when the word is accepted.
   task automatic checkOutput(input int idx, input logic v, input logic r,
                              input logic [11:0] d, input logic w);
      expWord_t e;
      if (v && !prevValid[idx]) riseWrap[idx] = w;
      if (v && r) begin
         checks++;
         if (sbQueue[idx].size() == 0) begin
            errors++;
            $display("[TB] FAIL word%0d unexpected: got data %h wrap %b, want none", idx, d, riseWrap[idx]);
         end else begin
            e = sbQueue[idx].pop_front();
            if (d !== e.data || riseWrap[idx] !== e.wrap) begin
               errors++;
               $display("[TB] FAIL word%0d: got data %h wrap %b, want data %h wrap %b",
                        idx, d, riseWrap[idx], e.data, e.wrap);
            end
         end
      end
      prevValid[idx] = v;
   endtask

   // Monitor samples 2 time units after each falling edge, after stimulus settles.
   initial begin
      for (int i = 0; i < 3; i++) begin
         prevValid[i] = 1'b0;
         riseWrap[i]  = 1'b0;
      end
      forever begin
         @(negedge clk);
         #2;
         checkOutput(0, valid1, rdy1, data1, wrap1);
         checkOutput(1, valid2, rdy2, data2, wrap2);
         checkOutput(2, valid4, rdy4, data4, wrap4);
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Sequence for the STEPS=1 instance: latency, backpressure, loads, full period.
   task automatic runDut1();
      logic [11:0] s;
      int wrapCount;
      bit  drained;
      tick(3);
      expectEq("rst_valid", 32'(valid1), 32'd0);
      expectEq("rst_data", 32'(data1), 32'h000);
      expectEq("rst_wrap", 32'(wrap1), 32'd0);

      pushExp(0, 12'h59D, 1'b0);
      pushExp(0, 12'hB3A, 1'b0);
      pushExp(0, 12'h675, 1'b0);
      rst1 = 1'b0;
      applyStimulus1(1'b1, 1'b1, 1'b0, 12'h000);
      tick(1);
      expectEq("latency_valid", 32'(valid1), 32'd1);
      expectEq("latency_data", 32'(data1), 32'h59D);
      tick(1);
      expectEq("gap_valid", 32'(valid1), 32'd0);
      tick(5);
      expectEq("fourth_data", 32'(data1), 32'hCEA);

      applyStimulus1(1'b1, 1'b0, 1'b0, 12'h000);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         expectEq("bp_valid", 32'(valid1), 32'd1);
         expectEq("bp_data", 32'(data1), 32'hCEA);
      end
      pushExp(0, 12'hCEA, 1'b0);
      pushExp(0, 12'h9D5, 1'b0);
      applyStimulus1(1'b1, 1'b1, 1'b0, 12'h000);
      tick(2);
      expectEq("after_bp_data", 32'(data1), 32'h9D5);

      // Zero seed load coinciding with an accepted transfer.
      applyStimulus1(1'b1, 1'b1, 1'b1, 12'h000);
      tick(1);
      expectEq("load0_valid", 32'(valid1), 32'd0);
      expectEq("load0_wrap", 32'(wrap1), 32'd0);
      applyStimulus1(1'b1, 1'b0, 1'b0, 12'h000);
      tick(1);
      expectEq("load0_word_valid", 32'(valid1), 32'd1);
      expectEq("load0_word_data", 32'(data1), 32'h59D);
      expectEq("load0_word_wrap", 32'(wrap1), 32'd0);

      // Seed 1 loaded while a word is parked.
      applyStimulus1(1'b1, 1'b0, 1'b1, 12'h001);
      tick(1);
      expectEq("load1_valid", 32'(valid1), 32'd0);
      expectEq("load1_wrap", 32'(wrap1), 32'd0);
      pushExp(0, 12'h002, 1'b0);
      pushExp(0, 12'h004, 1'b0);
      applyStimulus1(1'b1, 1'b1, 1'b0, 12'h000);
      tick(4);

      // Full period from reset: wrap only on the 4095th shift.
      rst1 = 1'b1;
      applyStimulus1(1'b0, 1'b1, 1'b0, 12'h000);
      tick(2);
      expectEq("rst2_valid", 32'(valid1), 32'd0);
      expectEq("rst2_data", 32'(data1), 32'h000);
      s = 12'hACE;
      for (int i = 1; i <= 4096; i++) begin
         s = lfsrStep(s);
         pushExp(0, s, (s == 12'hACE));
      end
      rst1 = 1'b0;
      applyStimulus1(1'b1, 1'b1, 1'b0, 12'h000);
      wrapCount = 0;
      drained   = 1'b0;
      for (int i = 0; i < 8400; i++) begin
         tick(1);
         if (wrap1) wrapCount++;
         if (sbQueue[0].size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
      applyStimulus1(1'b0, 1'b1, 1'b0, 12'h000);
      expectEq("period_drained", 32'(drained), 32'd1);
      expectEq("period_wrap_count", 32'(wrapCount), 32'd1);
   endtask

   // Sequences for the STEPS=2 and STEPS=4 instances.
   task automatic runDut24();
      tick(3);
      expectEq("s2_rst_valid", 32'(valid2), 32'd0);
      pushExp(1, 12'hB3A, 1'b0);
      pushExp(1, 12'hCEA, 1'b0);
      rst2 = 1'b0;
      en2  = 1'b1;
      rdy2 = 1'b1;
      tick(1);
      expectEq("s2_early_valid", 32'(valid2), 32'd0);
      tick(1);
      expectEq("s2_first_valid", 32'(valid2), 32'd1);
      expectEq("s2_first_data", 32'(data2), 32'hB3A);
      tick(4);
      en2 = 1'b0;

      pushExp(2, 12'hCEA, 1'b0);
      pushExp(2, 12'hEAC, 1'b0);
      rst4 = 1'b0;
      en4  = 1'b1;
      rdy4 = 1'b1;
      tick(2);
      en4 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         expectEq("s4_frozen_valid", 32'(valid4), 32'd0);
      end
      en4 = 1'b1;
      tick(1);
      expectEq("s4_resume_valid", 32'(valid4), 32'd0);
      tick(1);
      expectEq("s4_word_valid", 32'(valid4), 32'd1);
      expectEq("s4_word_data", 32'(data4), 32'hCEA);
      tick(6);
      en4 = 1'b0;
   endtask

   // Main control: reset everything, run both sequences, then summarise.
   initial begin
      checks = 0;
      errors = 0;
      rst1 = 1'b1; en1 = 1'b0; ld1 = 1'b0; rdy1 = 1'b0; seed1 = 12'h000;
      rst2 = 1'b1; en2 = 1'b0; ld2 = 1'b0; rdy2 = 1'b0; seed2 = 12'h000;
      rst4 = 1'b1; en4 = 1'b0; ld4 = 1'b0; rdy4 = 1'b0; seed4 = 12'h000;
      $display("[TB] starting rng_lfsr_gen bench");
      fork
         runDut1();
         runDut24();
      join
      tick(4);
      for (int i = 0; i < 3; i++) begin
         expectEq($sformatf("queue%0d_empty", i), 32'(sbQueue[i].size()), 32'd0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
